// File: rtl/elevator_call_scheduler_if.sv
// Bus bundle for elevator_call_scheduler: button pulses and car status in,
// dispatch target, sweep direction and lamp masks out.
// master = car controller / button panel side, slave = the scheduler.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] car_call;
    logic [NUM_FLOORS-1:0] hall_up;
    logic [NUM_FLOORS-1:0] hall_down;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  car_moving;
    logic                  service_done;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic [1:0]            sweep_dir;
    logic [NUM_FLOORS-1:0] pend_car;
    logic [NUM_FLOORS-1:0] pend_up;
    logic [NUM_FLOORS-1:0] pend_down;

    modport master (
        output car_call, hall_up, hall_down, car_floor, car_moving, service_done,
        input  target_floor, target_valid, sweep_dir, pend_car, pend_up, pend_down
    );

    modport slave (
        input  car_call, hall_up, hall_down, car_floor, car_moving, service_done,
        output target_floor, target_valid, sweep_dir, pend_car, pend_up, pend_down
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches cabin/hall calls and picks the next
// target floor with a LOOK sweep (IDLE / UP / DOWN).
// Floors are numbered 1..NUM_FLOORS, floor value 0 means "none".
// Optional feature macro: PARKING_EN -- after PARK_TIMEOUT idle clocks with
// no calls the car is sent to PARK_FLOOR without setting any pend bit.
// A service_done while car_moving is set is treated as spurious and ignored.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS   = 7,
    parameter int FLOOR_W      = 3
`ifdef PARKING_EN
    ,
    parameter int PARK_FLOOR   = 1,
    parameter int PARK_TIMEOUT = 5000
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    elevator_call_scheduler_if.slave  bus
);

    // State codes double as the sweep_dir encoding {up, down}.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b10;
    localparam logic [1:0] ST_DOWN = 2'b01;

    // Top floor has no UP button, bottom floor has no DOWN button.
    localparam logic [NUM_FLOORS-1:0] UP_OK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    logic [NUM_FLOORS-1:0] pend_car_q, pend_car_d;
    logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [NUM_FLOORS-1:0] pend_down_q, pend_down_d;
    logic [1:0]            state_q, state_d;
    logic [1:0]            dir_q, dir_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  target_valid_q;

    logic                  floor_ok_s;
    logic                  svc_s;
    logic [NUM_FLOORS-1:0] any_s;
    logic [NUM_FLOORS-1:0] above_s, below_s, at_s;
    logic                  beyond_up_s, beyond_dn_s, here_s;
    logic [FLOOR_W-1:0]    up_near_s, up_far_s, dn_near_s, dn_far_s;
    logic [FLOOR_W-1:0]    near_above_s, near_below_s;
    logic [FLOOR_W-1:0]    up_tgt_s, dn_tgt_s;
    logic [FLOOR_W-1:0]    dist_up_s, dist_dn_s;
    logic [NUM_FLOORS-1:0] clr_car_s, clr_up_s, clr_dn_s;

`ifdef PARKING_EN
    localparam int                 CNT_W   = $clog2(PARK_TIMEOUT + 1);
    localparam logic [FLOOR_W-1:0] PARK_FL = FLOOR_W'(PARK_FLOOR);
    logic             park_q, park_d;
    logic [CNT_W-1:0] park_cnt_q, park_cnt_d;
    logic             press_s;
    logic [1:0]       park_dir_s;
`endif

    assign floor_ok_s = (bus.car_floor >= FLOOR_W'(1)) && (bus.car_floor <= FLOOR_W'(NUM_FLOORS));
    assign svc_s      = bus.service_done && !bus.car_moving && floor_ok_s;
    assign any_s      = pend_car_q | pend_up_q | pend_down_q;

    // Position masks relative to the current car floor.
    always_comb begin
        above_s = '0;
        below_s = '0;
        at_s    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_s[i] = (FLOOR_W'(i + 1) >  bus.car_floor);
            below_s[i] = (FLOOR_W'(i + 1) <  bus.car_floor);
            at_s[i]    = (FLOOR_W'(i + 1) == bus.car_floor);
        end
    end

    assign beyond_up_s = |(any_s & above_s);
    assign beyond_dn_s = |(any_s & below_s);
    assign here_s      = |(any_s & at_s);

    // Candidate searches; downward loops keep the lowest hit, upward loops the highest.
    always_comb begin
        up_near_s    = '0;
        up_far_s     = '0;
        dn_near_s    = '0;
        dn_far_s     = '0;
        near_above_s = '0;
        near_below_s = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            up_near_s    = (above_s[i] && (pend_car_q[i] || pend_up_q[i])) ? FLOOR_W'(i + 1) : up_near_s;
            near_above_s = (above_s[i] && any_s[i]) ? FLOOR_W'(i + 1) : near_above_s;
            dn_far_s     = (below_s[i] && pend_up_q[i]) ? FLOOR_W'(i + 1) : dn_far_s;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            up_far_s     = (above_s[i] && pend_down_q[i]) ? FLOOR_W'(i + 1) : up_far_s;
            dn_near_s    = (below_s[i] && (pend_car_q[i] || pend_down_q[i])) ? FLOOR_W'(i + 1) : dn_near_s;
            near_below_s = (below_s[i] && any_s[i]) ? FLOOR_W'(i + 1) : near_below_s;
        end
    end

    assign up_tgt_s  = (up_near_s != '0) ? up_near_s : up_far_s;
    assign dn_tgt_s  = (dn_near_s != '0) ? dn_near_s : dn_far_s;
    assign dist_up_s = near_above_s - bus.car_floor;
    assign dist_dn_s = bus.car_floor - near_below_s;

    // Call clearing at the serviced floor; opposite-direction hall call clears at the sweep end.
    always_comb begin
        clr_car_s = svc_s ? at_s : '0;
        clr_up_s  = '0;
        clr_dn_s  = '0;
        if (svc_s) begin
            case (state_q)
                ST_UP: begin
                    clr_up_s = at_s;
                    clr_dn_s = beyond_up_s ? '0 : at_s;
                end
                ST_DOWN: begin
                    clr_dn_s = at_s;
                    clr_up_s = beyond_dn_s ? '0 : at_s;
                end
                default: begin
                    clr_up_s = at_s;
                    clr_dn_s = at_s;
                end
            endcase
        end else begin
            clr_up_s = '0;
            clr_dn_s = '0;
        end
    end

    // Latch new presses; a clear on the same bit in the same cycle wins.
    always_comb begin
        pend_car_d  = (pend_car_q  | bus.car_call)            & ~clr_car_s;
        pend_up_d   = (pend_up_q   | (bus.hall_up   & UP_OK)) & ~clr_up_s;
        pend_down_d = (pend_down_q | (bus.hall_down & DN_OK)) & ~clr_dn_s;
    end

`ifdef PARKING_EN
    assign press_s    = (|bus.car_call) || (|(bus.hall_up & UP_OK)) || (|(bus.hall_down & DN_OK));
    assign park_dir_s = (PARK_FL > bus.car_floor) ? ST_UP :
                        ((PARK_FL < bus.car_floor) ? ST_DOWN : ST_IDLE);

    // Idle counter: runs only while IDLE with nothing pending and nothing pressed.
    always_comb begin
        if ((state_q == ST_IDLE) && !(|any_s) && !press_s) begin
            park_cnt_d = (park_cnt_q == CNT_W'(PARK_TIMEOUT)) ? park_cnt_q : park_cnt_q + CNT_W'(1);
        end else begin
            park_cnt_d = '0;
        end
    end
`endif

    // LOOK sweep: next state, target and direction; a reversal holds the old target one cycle.
    always_comb begin
        state_d = state_q;
        target_d = target_q;
        dir_d = dir_q;
        if (floor_ok_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (here_s) begin
                        target_d = bus.car_floor;
                        dir_d    = ST_IDLE;
                    end else if ((near_above_s != '0) && ((near_below_s == '0) || (dist_up_s <= dist_dn_s))) begin
                        state_d  = ST_UP;
                        dir_d    = ST_UP;
                        target_d = up_tgt_s;
                    end else if (near_below_s != '0) begin
                        state_d  = ST_DOWN;
                        dir_d    = ST_DOWN;
                        target_d = dn_tgt_s;
                    end else begin
                        target_d = '0;
                        dir_d    = ST_IDLE;
                    end
                end
                ST_UP: begin
                    if (up_tgt_s != '0) begin
                        target_d = up_tgt_s;
                    end else if (beyond_dn_s) begin
                        state_d = ST_DOWN;
                        dir_d   = ST_DOWN;
                    end else begin
                        state_d  = ST_IDLE;
                        dir_d    = ST_IDLE;
                        target_d = here_s ? bus.car_floor : '0;
                    end
                end
                ST_DOWN: begin
                    if (dn_tgt_s != '0) begin
                        target_d = dn_tgt_s;
                    end else if (beyond_up_s) begin
                        state_d = ST_UP;
                        dir_d   = ST_UP;
                    end else begin
                        state_d  = ST_IDLE;
                        dir_d    = ST_IDLE;
                        target_d = here_s ? bus.car_floor : '0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    dir_d    = ST_IDLE;
                    target_d = '0;
                end
            endcase
        end else begin
            state_d  = state_q;
            target_d = target_q;
            dir_d    = dir_q;
        end
`ifdef PARKING_EN
        park_d = floor_ok_s ? 1'b0 : park_q;
        if (floor_ok_s && (state_q == ST_IDLE) && !(|any_s)) begin
            if (park_q && !(svc_s && (bus.car_floor == PARK_FL))) begin
                park_d   = 1'b1;
                target_d = PARK_FL;
                dir_d    = park_dir_s;
            end else if (!park_q && (park_cnt_q == CNT_W'(PARK_TIMEOUT)) && (bus.car_floor != PARK_FL)) begin
                park_d   = 1'b1;
                target_d = PARK_FL;
                dir_d    = park_dir_s;
            end else begin
                park_d = 1'b0;
            end
        end else begin
            park_d = floor_ok_s ? 1'b0 : park_q;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_car_q     <= '0;
            pend_up_q      <= '0;
            pend_down_q    <= '0;
            state_q        <= ST_IDLE;
            dir_q          <= ST_IDLE;
            target_q       <= '0;
            target_valid_q <= 1'b0;
        end else begin
            pend_car_q     <= pend_car_d;
            pend_up_q      <= pend_up_d;
            pend_down_q    <= pend_down_d;
            state_q        <= state_d;
            dir_q          <= dir_d;
            target_q       <= target_d;
            target_valid_q <= (target_d != '0);
        end
    end

`ifdef PARKING_EN
    // Parking counter and parking-active flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            park_cnt_q <= '0;
            park_q     <= 1'b0;
        end else begin
            park_cnt_q <= park_cnt_d;
            park_q     <= park_d;
        end
    end
`endif

    assign bus.target_floor = target_q;
    assign bus.target_valid = target_valid_q;
    assign bus.sweep_dir    = dir_q;
    assign bus.pend_car     = pend_car_q;
    assign bus.pend_up      = pend_up_q;
    assign bus.pend_down    = pend_down_q;

endmodule
